sn_period_sequencer: RTL

Sequences one spiking-network run as a series of simulation periods. For each period it requests input spikes, strobes the neuron array for a programmable number of steps, waits for the network to settle, then hands the output spikes to the UART protocol layer. It sits between the protocol/command decoder and the neuron array inside the network top, and replaces ad-hoc period counting in the protocol logic.

---
 rtl/sn_period_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sn_period_sequencer.sv
// Period sequencer for one spiking-network run: input load, neuron stepping, settle, output report.
// Optional stall watchdog enabled by defining SN_SEQ_WATCHDOG_EN.
module sn_period_sequencer #(
  parameter int  P_MAX_NUM_PERIODS   = 50000,
  parameter int  P_NEUR_STEP_CNTR_BW = 8,
  parameter int  P_DFLT_CNTR_VAL     = 40,
  parameter int  P_WATCHDOG_CYCLES   = 1000000,
  localparam int L_PER_BW            = $clog2(P_MAX_NUM_PERIODS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [L_PER_BW-1:0]            num_periods_i,
  input  logic [P_NEUR_STEP_CNTR_BW-1:0] step_cnt_i,
  input  logic                           abort_i,
  output logic                           in_req_o,
  input  logic                           in_ack_i,
  output logic                           neur_step_o,
  input  logic                           neur_idle_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [L_PER_BW-1:0]            period_idx_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic                           aborted_o
);

  // state  | meaning
  // IDLE   | waiting for a legal start
  // LOAD   | in_req_o high until in_ack_i
  // STEP   | neur_step_o high for the effective step count
  // SETTLE | waiting for neur_idle_i
  // REPORT | out_valid_o high until out_ready_i
  // DONE   | one-cycle done_o, then IDLE
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STEP   = 3'd2,
    S_SETTLE = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [L_PER_BW-1:0]            L_MAX_PER   = L_PER_BW'(P_MAX_NUM_PERIODS);
  localparam logic [L_PER_BW-1:0]            L_PER_ONE   = L_PER_BW'(1);
  localparam logic [P_NEUR_STEP_CNTR_BW-1:0] L_DFLT_STEP = P_NEUR_STEP_CNTR_BW'(P_DFLT_CNTR_VAL);
  localparam logic [P_NEUR_STEP_CNTR_BW-1:0] L_STEP_ONE  = P_NEUR_STEP_CNTR_BW'(1);

  state_t state_q;
  state_t state_nxt;

  logic [L_PER_BW-1:0]            num_last_q;
  logic [P_NEUR_STEP_CNTR_BW-1:0] step_eff_q;
  logic [P_NEUR_STEP_CNTR_BW-1:0] step_cnt_q;
  logic [P_NEUR_STEP_CNTR_BW-1:0] step_eff_in;

  logic start_legal;
  logic start_ok;
  logic start_bad;
  logic abort_hit;
  logic step_load;
  logic period_inc;
  logic wd_expired;
  logic wd_timeout;

  logic in_req_nxt;
  logic neur_step_nxt;
  logic out_valid_nxt;
  logic busy_nxt;
  logic done_nxt;
  logic err_nxt;
  logic aborted_nxt;

  assign start_legal = (num_periods_i != '0) && (num_periods_i <= L_MAX_PER);
  assign step_eff_in = (step_cnt_i == '0) ? L_DFLT_STEP : step_cnt_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    abort_hit  = 1'b0;
    step_load  = 1'b0;
    period_inc = 1'b0;
    wd_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (start_legal) begin
            start_ok  = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (in_ack_i) begin
          step_load = 1'b1;
          state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (step_cnt_q == L_STEP_ONE) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (neur_idle_i) begin
          state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        if (out_ready_i) begin
          if (period_idx_o == num_last_q) begin
            state_nxt = S_DONE;
          end else begin
            period_inc = 1'b1;
            state_nxt  = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // A handshake arriving in the expiry cycle still counts as progress.
    wd_timeout = wd_expired && (state_nxt == state_q);

    if ((state_q != S_IDLE) && abort_i) begin
      abort_hit  = 1'b1;
      step_load  = 1'b0;
      period_inc = 1'b0;
      state_nxt  = S_IDLE;
    end else if (wd_timeout) begin
      step_load  = 1'b0;
      period_inc = 1'b0;
      state_nxt  = S_IDLE;
    end
  end

  always_comb begin
    in_req_nxt    = (state_nxt == S_LOAD);
    neur_step_nxt = (state_nxt == S_STEP);
    out_valid_nxt = (state_nxt == S_REPORT);
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = (state_nxt == S_DONE);
    err_nxt       = start_bad || wd_timeout;
    aborted_nxt   = abort_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_req_o    <= 1'b0;
      neur_step_o <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      aborted_o   <= 1'b0;
    end else begin
      in_req_o    <= in_req_nxt;
      neur_step_o <= neur_step_nxt;
      out_valid_o <= out_valid_nxt;
      busy_o      <= busy_nxt;
      done_o      <= done_nxt;
      err_o       <= err_nxt;
      aborted_o   <= aborted_nxt;
    end
  end

  // Run configuration is latched only on a legal start; period_idx holds after DONE/abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_last_q   <= '0;
      step_eff_q   <= '0;
      step_cnt_q   <= '0;
      period_idx_o <= '0;
    end else begin
      if (start_ok) begin
        num_last_q   <= num_periods_i - L_PER_ONE;
        step_eff_q   <= step_eff_in;
        period_idx_o <= '0;
      end else if (period_inc) begin
        period_idx_o <= period_idx_o + L_PER_ONE;
      end

      if (step_load) begin
        step_cnt_q <= step_eff_q;
      end else if ((state_q == S_STEP) && (step_cnt_q != '0)) begin
        step_cnt_q <= step_cnt_q - L_STEP_ONE;
      end
    end
  end

`ifdef SN_SEQ_WATCHDOG_EN
  localparam int                 L_WD_BW   = $clog2(P_WATCHDOG_CYCLES + 1);
  localparam logic [L_WD_BW-1:0] L_WD_LOAD = L_WD_BW'(P_WATCHDOG_CYCLES - 1);
  localparam logic [L_WD_BW-1:0] L_WD_ONE  = L_WD_BW'(1);

  logic [L_WD_BW-1:0] wd_cnt_q;
  logic               wd_wait;

  assign wd_wait    = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_REPORT);
  assign wd_expired = wd_wait && (wd_cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= L_WD_LOAD;
    end else if (state_nxt != state_q) begin
      wd_cnt_q <= L_WD_LOAD;
    end else if (wd_wait && (wd_cnt_q != '0)) begin
      wd_cnt_q <= wd_cnt_q - L_WD_ONE;
    end
  end
`else
  logic unused_wd_cfg;

  assign unused_wd_cfg = (P_WATCHDOG_CYCLES == 0);
  assign wd_expired    = 1'b0;
`endif

endmodule
